// File: rtl/mult_booth_pkg.sv
// -----------------------------------------------------------------------------
// mult_booth_pkg
// Shared MIPS arithmetic components package. Holds the state encodings and
// constants used by the multi-cycle HI/LO units (Booth multiplier, divider).
// No ports; import with "import mult_booth_pkg::*;".
// -----------------------------------------------------------------------------
package mult_booth_pkg;

    // Multiplier control FSM states
    typedef enum logic [1:0] {
        MULT_IDLE = 2'b00,
        MULT_RUN  = 2'b01,
        MULT_DONE = 2'b10
    } mult_state_t;

    // Divider control FSM states (the divider shares this package)
    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_RUN  = 2'b01,
        DIV_DONE = 2'b10
    } div_state_t;

    // Booth recoding of {Q0, Q-1}
    localparam logic [1:0] BOOTH_NOP_LO = 2'b00;
    localparam logic [1:0] BOOTH_ADD    = 2'b01;
    localparam logic [1:0] BOOTH_SUB    = 2'b10;
    localparam logic [1:0] BOOTH_NOP_HI = 2'b11;

endpackage

// File: rtl/mult_booth_step.sv
// -----------------------------------------------------------------------------
// booth_step
// Combinational datapath for one radix-2 Booth iteration: conditional
// add/subtract of M into A, followed by an arithmetic right shift of
// {A, Q, Q-1}. All arithmetic is WIDTH+1 bits; carries out are dropped.
// Ports:
//   a_i, q_i, m_i  current accumulator, multiplier shift register, multiplicand
//   qm1_i          current Q-1 bit
//   a_o, q_o       accumulator and multiplier after add and shift
//   qm1_o          new Q-1 bit (old Q0)
// -----------------------------------------------------------------------------
module booth_step
    import mult_booth_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] a_i,
    input  logic [WIDTH:0] q_i,
    input  logic [WIDTH:0] m_i,
    input  logic           qm1_i,
    output logic [WIDTH:0] a_o,
    output logic [WIDTH:0] q_o,
    output logic           qm1_o
);

    logic [WIDTH:0] sum_s;

    // Booth add/subtract selection then arithmetic shift of {A,Q,Q-1}
    always_comb begin
        sum_s = a_i;
        case ({q_i[0], qm1_i})
            BOOTH_ADD:    sum_s = a_i + m_i;
            BOOTH_SUB:    sum_s = a_i - m_i;
            BOOTH_NOP_LO: sum_s = a_i;
            BOOTH_NOP_HI: sum_s = a_i;
            default:      sum_s = a_i;
        endcase
        a_o   = {sum_s[WIDTH], sum_s[WIDTH:1]};
        q_o   = {sum_s[0], q_i[WIDTH:1]};
        qm1_o = q_i[0];
    end

endmodule

// File: rtl/mult_booth.sv
// -----------------------------------------------------------------------------
// mult_booth
// Multi-cycle radix-2 Booth multiplier feeding the HI/LO registers (mult and
// multu). Operands are extended by one bit (sign or zero) so a single signed
// Booth engine of WIDTH+1 bits serves both flavours; the low 2*WIDTH bits of
// the (2*WIDTH+2)-bit result are the exact product in either case.
// All state updates on the falling clock edge, like the divider.
// Ports:
//   clk            clock (falling edge active)
//   reset          asynchronous active-high reset
//   MultStart      start request, sampled only while idle
//   MultSigned     1 = signed, 0 = unsigned; sampled with MultStart
//   multiplicando  first operand
//   multiplicador  second operand
//   hi, lo         upper/lower half of the product, held between completions
//   MultEnd        one-cycle completion pulse
//   MultBusy       high while an operation is in progress (RUN and DONE)
// -----------------------------------------------------------------------------
module mult_booth
    import mult_booth_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEPS = WIDTH + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MultStart,
    input  logic             MultSigned,
    input  logic [WIDTH-1:0] multiplicando,
    input  logic [WIDTH-1:0] multiplicador,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             MultEnd,
    output logic             MultBusy
);

    localparam int CW = $clog2(STEPS + 1);

    mult_state_t      state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH:0]   q_q, q_d;
    logic [WIDTH:0]   m_q, m_d;
    logic             qm1_q, qm1_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             end_q, end_d;
    logic             busy_q, busy_d;

    logic [WIDTH:0]   step_a_s;
    logic [WIDTH:0]   step_q_s;
    logic             step_qm1_s;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a_i   (a_q),
        .q_i   (q_q),
        .m_i   (m_q),
        .qm1_i (qm1_q),
        .a_o   (step_a_s),
        .q_o   (step_q_s),
        .qm1_o (step_qm1_s)
    );

    // State and datapath registers, falling-edge with async reset
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MULT_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            end_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            end_q   <= end_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        end_d   = 1'b0;

        case (state_q)
            MULT_IDLE: begin
                if (MultStart) begin
                    m_d     = {MultSigned & multiplicando[WIDTH-1], multiplicando};
                    q_d     = {MultSigned & multiplicador[WIDTH-1], multiplicador};
                    a_d     = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = MULT_RUN;
                end else begin
                    state_d = MULT_IDLE;
                end
            end
            MULT_RUN: begin
                if (cnt_q == CW'(STEPS)) begin
                    // Low 2*WIDTH bits of {A,Q}: A[WIDTH-2:0], then all of Q
                    hi_d    = {a_q[WIDTH-2:0], q_q[WIDTH]};
                    lo_d    = q_q[WIDTH-1:0];
                    end_d   = 1'b1;
                    state_d = MULT_DONE;
                end else begin
                    a_d   = step_a_s;
                    q_d   = step_q_s;
                    qm1_d = step_qm1_s;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            MULT_DONE: begin
                state_d = MULT_IDLE;
            end
            default: begin
                state_d = MULT_IDLE;
            end
        endcase

        busy_d = (state_d != MULT_IDLE);
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign MultEnd  = end_q;
    assign MultBusy = busy_q;

endmodule

// File: tb/tb_mult_booth.sv
// -----------------------------------------------------------------------------
// tb_mult_booth
// Directed self-checking bench for mult_booth (WIDTH=32). Inputs are driven
// and outputs sampled on the rising edge, away from the active falling edge.
// -----------------------------------------------------------------------------
module tb_mult_booth;

    logic        clk;
    logic        reset;
    logic        MultStart;
    logic        MultSigned;
    logic [31:0] multiplicando;
    logic [31:0] multiplicador;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        MultEnd;
    logic        MultBusy;

    int n_total;
    int n_pass;

    mult_booth #(
        .WIDTH (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .MultStart     (MultStart),
        .MultSigned    (MultSigned),
        .multiplicando (multiplicando),
        .multiplicador (multiplicador),
        .hi            (hi),
        .lo            (lo),
        .MultEnd       (MultEnd),
        .MultBusy      (MultBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Present a start request for exactly one falling edge
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        @(posedge clk);
        MultStart     = 1'b1;
        MultSigned    = sgn;
        multiplicando = a;
        multiplicador = b;
        @(posedge clk);
        MultStart     = 1'b0;
    endtask

    // Full operation: latency, product, hi/lo stability, pulse width, idle
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [63:0] exp);
        int          cyc;
        int          changes;
        logic [63:0] prev;
        start_op(a, b, sgn);
        check({tag, " busy"}, {63'd0, MultBusy}, 64'd1);
        prev    = {hi, lo};
        changes = 0;
        cyc     = 0;
        while (!MultEnd && cyc < 60) begin
            @(posedge clk);
            cyc++;
            if (!MultEnd && ({hi, lo} !== prev)) changes++;
        end
        check({tag, " latency"}, 64'(cyc), 64'd34);
        check({tag, " product"}, {hi, lo}, exp);
        check({tag, " stable"}, 64'(changes), 64'd0);
        @(posedge clk);
        check({tag, " end_pulse"}, {63'd0, MultEnd}, 64'd0);
        check({tag, " idle"}, {63'd0, MultBusy}, 64'd0);
    endtask

    initial begin
        int          cyc;
        int          ends;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic [63:0] rexp;

        n_total       = 0;
        n_pass        = 0;
        reset         = 1'b1;
        MultStart     = 1'b0;
        MultSigned    = 1'b0;
        multiplicando = 32'd0;
        multiplicador = 32'd0;

        repeat (3) @(posedge clk);
        check("rst hi", {32'd0, hi}, 64'd0);
        check("rst lo", {32'd0, lo}, 64'd0);
        check("rst end", {63'd0, MultEnd}, 64'd0);
        check("rst busy", {63'd0, MultBusy}, 64'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        check("post-rst busy", {63'd0, MultBusy}, 64'd0);

        run_op("s 7x-3", 32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("s min^2", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        run_op("u min^2", 32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000);
        run_op("u max^2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        run_op("s -1^2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);

        // Reset in the middle of RUN aborts without a completion pulse
        start_op(32'h0000_1234, 32'h0000_0010, 1'b0);
        repeat (9) @(posedge clk);
        reset = 1'b1;
        #1;
        check("abort hi", {32'd0, hi}, 64'd0);
        check("abort lo", {32'd0, lo}, 64'd0);
        check("abort busy", {63'd0, MultBusy}, 64'd0);
        check("abort end", {63'd0, MultEnd}, 64'd0);
        @(posedge clk);
        reset = 1'b0;
        ends = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (MultEnd) ends++;
        end
        check("abort no end", 64'(ends), 64'd0);
        check("abort still idle", {63'd0, MultBusy}, 64'd0);
        run_op("u 1234x10", 32'h0000_1234, 32'h0000_0010, 1'b0, 64'h0000_0000_0001_2340);

        run_op("s max*min", 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000);
        run_op("u max*min", 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 64'h3FFF_FFFF_8000_0000);
        run_op("u min*2", 32'h8000_0000, 32'h0000_0002, 1'b0, 64'h0000_0001_0000_0000);
        run_op("s 0*min", 32'h0000_0000, 32'h8000_0000, 1'b1, 64'h0000_0000_0000_0000);

        // MultStart held high; operands change during RUN and must be ignored
        @(posedge clk);
        MultStart     = 1'b1;
        MultSigned    = 1'b0;
        multiplicando = 32'd3;
        multiplicador = 32'd4;
        @(posedge clk);
        multiplicando = 32'd9;
        multiplicador = 32'd9;
        cyc = 0;
        while (!MultEnd && cyc < 60) begin
            @(posedge clk);
            cyc++;
        end
        check("held first latency", 64'(cyc), 64'd34);
        check("held first product", {hi, lo}, 64'd12);
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
        end while (!MultEnd && cyc < 80);
        MultStart = 1'b0;
        check("held gap", 64'(cyc), 64'd36);
        check("held second product", {hi, lo}, 64'd81);
        @(posedge clk);
        check("held end_pulse", {63'd0, MultEnd}, 64'd0);
        @(posedge clk);
        check("held idle", {63'd0, MultBusy}, 64'd0);

        // Small randomized batch against a 64-bit reference product
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (rs) begin
                rexp = 64'(longint'($signed(ra)) * longint'($signed(rb)));
            end else begin
                rexp = {32'd0, ra} * {32'd0, rb};
            end
            run_op("rand", ra, rb, rs, rexp);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mult_booth.md
MULT_BOOTH -- requirements
Module: mult_booth

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits.
REQ-002 Parameter STEPS, default WIDTH+1, number of Booth iterations (derived; not overridden).
REQ-003 clk  input  1  clock; all state SHALL update on the falling edge, matching the datapath's divider timing.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 MultStart  input  1  start request, sampled only in IDLE.
REQ-006 MultSigned  input  1  1 = signed (mult), 0 = unsigned (multu); sampled with MultStart.
REQ-007 multiplicando  input  WIDTH  first operand.
REQ-008 multiplicador  input  WIDTH  second operand.
REQ-009 hi  output  WIDTH  upper half of product (to MFHI).
REQ-010 lo  output  WIDTH  lower half of product (to MFLO).
REQ-011 MultEnd  output  1  one-cycle completion pulse.
REQ-012 MultBusy  output  1  high while an operation is in progress.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
REQ-014 IDLE with MultStart=1: latch operands extended to WIDTH+1 bits (sign-extended if MultSigned, zero-extended otherwise); clear accumulator A (WIDTH+1 bits) and Q-1; counter=0; go to RUN.
REQ-015 RUN, each edge: {Q0,Q-1}=01 -> A=A+M; 10 -> A=A-M; 00/11 -> no add; then arithmetic right shift of {A,Q,Q-1}; counter+1.
REQ-016 After STEPS iterations, RUN SHALL go to DONE; on that edge {hi,lo} SHALL load the low 2*WIDTH bits of {A,Q}.
REQ-017 DONE SHALL assert MultEnd for exactly one cycle, then return to IDLE.
REQ-018 Latency: MultStart sampled at edge N -> MultEnd high from edge N+STEPS+1 for one cycle (34 cycles at WIDTH=32).
REQ-019 hi/lo SHALL hold their value from completion until the next completion; they SHALL NOT change during RUN.
REQ-020 MultBusy SHALL be 1 in RUN and DONE, 0 in IDLE.
REQ-021 MultStart in RUN or DONE SHALL be ignored; operands SHALL NOT be re-latched.
REQ-022 If MultStart stays high, a new operation SHALL start on the first IDLE edge after DONE (back-to-back, one idle cycle).
REQ-023 All add/subtract operations SHALL be WIDTH+1 bits wide, overflow discarded; no exceptions raised, including for the most negative operand.

Reset
REQ-024 reset SHALL force IDLE immediately; hi=0, lo=0, MultEnd=0, MultBusy=0, A/Q/M/counter=0.
REQ-025 reset mid-RUN SHALL abort the operation; no MultEnd pulse after release; outputs as in REQ-024.
REQ-026 After reset release, the first falling edge with MultStart=1 SHALL start a fresh operation.

Structure
REQ-027 State encodings (IDLE/RUN/DONE) and the Booth opcode constants belong in the shared MIPS components package, alongside the divider's constants.
REQ-028 One sub-module, booth_step, is natural: combinational add/sub-and-shift of one iteration; the FSM, counter and registers live in mult_booth.

Verification
REQ-029 Signed 7 x -3 (0x00000007, 0xFFFFFFFD) -> after 34 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB, one-cycle MultEnd.
REQ-030 Signed 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000; unsigned on the same operands -> hi=0x40000000, lo=0x00000000.
REQ-031 Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; signed on the same operands -> hi=0x00000000, lo=0x00000001.
REQ-032 Start 0x1234 x 0x10, pulse reset at iteration 10 -> hi=lo=0, MultBusy=0, no MultEnd; next start completes correctly.
REQ-033 Assert MultStart with new operands during RUN -> result matches original operands; MultStart held high -> second result one idle cycle after the first MultEnd.
REQ-034 Random 10k signed/unsigned pairs -> {hi,lo} equals the reference 64-bit product; hi/lo stable during RUN.
